// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the seven-segment time display.
package fnd_pkg;

   // Active-low segment codes, bit order {dp,g,f,e,d,c,b,a}
   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_DASH  = 8'hBF;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Out-of-range digit marker; the decoder renders any non-BCD code as a dash
   localparam logic [3:0] BCD_DASH = 4'hA;

   typedef enum logic {
      VIEW_HM = 1'b0,
      VIEW_SC = 1'b1
   } view_t;

   typedef enum logic [1:0] {
      SET_NONE = 2'b00,
      SET_MIN  = 2'b01,
      SET_HOUR = 2'b10
   } set_t;

   // Active-low anode patterns, digit 0 is the rightmost
   localparam logic [3:0] COM_OFF = 4'b1111;
   localparam logic [3:0] COM_D0  = 4'b1110;
   localparam logic [3:0] COM_D1  = 4'b1101;
   localparam logic [3:0] COM_D2  = 4'b1011;
   localparam logic [3:0] COM_D3  = 4'b0111;

   typedef struct packed {
      view_t      view;
      set_t       set;
      logic [6:0] msec;
      logic [5:0] sec;
      logic [5:0] min;
      logic [4:0] hour;
   } snap_t;

   function automatic logic [3:0] com_pattern(input logic [1:0] idx);
      logic [3:0] pat;
      case (idx)
         2'd0:    pat = COM_D0;
         2'd1:    pat = COM_D1;
         2'd2:    pat = COM_D2;
         default: pat = COM_D3;
      endcase
      return pat;
   endfunction

   // The unused 2'b11 encoding behaves like normal display
   function automatic set_t set_norm(input logic [1:0] raw);
      set_t s;
      case (raw)
         2'b01:   s = SET_MIN;
         2'b10:   s = SET_HOUR;
         default: s = SET_NONE;
      endcase
      return s;
   endfunction

   // Returns {tens, ones}; values of 100 and above show as two dashes
   function automatic logic [7:0] bcd_pair(input logic [6:0] v);
      logic [7:0] pair;
      if (v >= 7'd100) begin
         pair = {BCD_DASH, BCD_DASH};
      end else begin
         pair = {4'(v / 7'd10), 4'(v % 7'd10)};
      end
      return pair;
   endfunction

endpackage

// File: rtl/fnd_seg_decoder.sv
// BCD digit plus decimal-point flag to active-low seven-segment pattern.
module fnd_seg_decoder
   import fnd_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       dp,
   output logic [7:0] seg
);

   // Digit lookup, then clear the dp bit when requested
   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
      if (dp) begin
         seg[7] = 1'b0;
      end
   end

endmodule

// File: rtl/fnd_time_mux.sv
// Scanning 4-digit common-anode display driver for the clock's time fields.
// Inputs are snapshotted once per frame; digits are drawn from the snapshot.
module fnd_time_mux
   import fnd_pkg::*;
#(
   parameter int unsigned P_SCAN_DIV    = 100_000,
   parameter int unsigned P_BLINK_TICKS = 50
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic       iView,
   input  logic [1:0] iSet,
   input  logic [6:0] imSec,
   input  logic [5:0] iSec,
   input  logic [5:0] iMin,
   input  logic [4:0] iHour,
   input  logic       imSec_Tick,
   output logic [3:0] oFnd_Com,
   output logic [7:0] oFnd_Data
);

   localparam int unsigned SCAN_W  = (P_SCAN_DIV > 1) ? $clog2(P_SCAN_DIV) : 1;
   localparam int unsigned BLINK_W = (P_BLINK_TICKS > 1) ? $clog2(P_BLINK_TICKS) : 1;
   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(P_SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(P_BLINK_TICKS - 1);

   logic [SCAN_W-1:0]  scan_cnt;
   logic [1:0]         digit_idx;
   logic               scan_wrap;
   logic               frame_end;

   snap_t              snap;

   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_phase;
   set_t               set_prev;
   set_t               set_live;
   logic               set_entry;

   logic [6:0]         hi_val;
   logic [6:0]         lo_val;
   logic [7:0]         hi_bcd;
   logic [7:0]         lo_bcd;
   logic [3:0]         cur_bcd;
   logic               dp_on;
   logic               blank;
   logic [7:0]         seg_code;

   assign scan_wrap = (scan_cnt == SCAN_LAST);
   assign frame_end = scan_wrap && (digit_idx == 2'd3);
   assign set_live  = set_norm(iSet);
   assign set_entry = (set_prev == SET_NONE) && (set_live != SET_NONE);

   // Digit slot timer and digit index
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         scan_cnt  <= '0;
         digit_idx <= 2'd0;
      end else if (scan_wrap) begin
         scan_cnt  <= '0;
         digit_idx <= digit_idx + 2'd1;
      end else begin
         scan_cnt  <= scan_cnt + SCAN_W'(1);
      end
   end

   // Capture all display inputs at the frame boundary so a frame never tears
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         snap <= '0;
      end else if (frame_end) begin
         snap.view <= view_t'(iView);
         snap.set  <= set_live;
         snap.msec <= imSec;
         snap.sec  <= iSec;
         snap.min  <= iMin;
         snap.hour <= iHour;
      end
   end

   // Blink timer; entering set mode restarts it visible, winning over a tick
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
         set_prev    <= SET_NONE;
      end else begin
         set_prev <= set_live;
         if (set_entry) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
         end else if (imSec_Tick) begin
            if (blink_cnt == BLINK_LAST) begin
               blink_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt   <= blink_cnt + BLINK_W'(1);
            end
         end
      end
   end

   // Pick the left/right field pair for the snapshot's view
   always_comb begin
      hi_val = '0;
      lo_val = '0;
      if (snap.view == VIEW_SC) begin
         hi_val = {1'b0, snap.sec};
         lo_val = snap.msec;
      end else begin
         hi_val = {2'b00, snap.hour};
         lo_val = {1'b0, snap.min};
      end
   end

   assign hi_bcd = bcd_pair(hi_val);
   assign lo_bcd = bcd_pair(lo_val);

   // Per-digit value, decimal point and set-mode blanking
   always_comb begin
      cur_bcd = lo_bcd[3:0];
      dp_on   = 1'b0;
      blank   = 1'b0;
      case (digit_idx)
         2'd0:    cur_bcd = lo_bcd[3:0];
         2'd1:    cur_bcd = lo_bcd[7:4];
         2'd2: begin
            cur_bcd = hi_bcd[3:0];
            dp_on   = (snap.view == VIEW_SC) || blink_phase;
         end
         default: cur_bcd = hi_bcd[7:4];
      endcase
      if ((snap.view == VIEW_HM) && !blink_phase) begin
         if ((snap.set == SET_HOUR) && digit_idx[1]) begin
            blank = 1'b1;
         end
         if ((snap.set == SET_MIN) && !digit_idx[1]) begin
            blank = 1'b1;
         end
      end
   end

   fnd_seg_decoder u_seg_decoder (
      .bcd (cur_bcd),
      .dp  (dp_on),
      .seg (seg_code)
   );

   // Registered pin drivers; anode keeps scanning even while a digit is blanked
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         oFnd_Com  <= COM_OFF;
         oFnd_Data <= SEG_BLANK;
      end else begin
         oFnd_Com  <= com_pattern(digit_idx);
         oFnd_Data <= blank ? SEG_BLANK : seg_code;
      end
   end

endmodule

// File: tb/tb_fnd_time_mux.sv
// Self-checking bench for fnd_time_mux with a short scan and blink period.
module tb_fnd_time_mux;

   localparam int P_SCAN  = 4;
   localparam int P_BLINK = 2;

   logic       iClk;
   logic       iRst;
   logic       iView;
   logic [1:0] iSet;
   logic [6:0] imSec;
   logic [5:0] iSec;
   logic [5:0] iMin;
   logic [4:0] iHour;
   logic       imSec_Tick;
   logic [3:0] oFnd_Com;
   logic [7:0] oFnd_Data;

   int n_vec  = 0;
   int n_miss = 0;

   logic [7:0] exp_q[$];
   logic [3:0] com_pat[4];

   typedef struct {
      logic       view;
      logic [1:0] set;
      logic [6:0] msec;
      logic [5:0] sec;
      logic [5:0] min;
      logic [4:0] hour;
      logic [7:0] d3;
      logic [7:0] d2;
      logic [7:0] d1;
      logic [7:0] d0;
   } vec_t;

   vec_t vecs[8];

   fnd_time_mux #(
      .P_SCAN_DIV    (P_SCAN),
      .P_BLINK_TICKS (P_BLINK)
   ) dut (
      .iClk       (iClk),
      .iRst       (iRst),
      .iView      (iView),
      .iSet       (iSet),
      .imSec      (imSec),
      .iSec       (iSec),
      .iMin       (iMin),
      .iHour      (iHour),
      .imSec_Tick (imSec_Tick),
      .oFnd_Com   (oFnd_Com),
      .oFnd_Data  (oFnd_Data)
   );

   initial begin
      iClk = 1'b0;
      forever #5 iClk = ~iClk;
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic wait_com(input logic [3:0] target, input string name);
      int  n;
      bit  found;
      n     = 0;
      found = 1'b0;
      while (!found && n < 64) begin
         if (oFnd_Com == target) begin
            found = 1'b1;
         end else begin
            @(negedge iClk);
            n++;
         end
      end
      if (!found) begin
         n_vec++;
         n_miss++;
         $display("FAIL %s_timeout: com %04b never reached %04b", name, oFnd_Com, target);
      end
   endtask

   task automatic push_frame(input logic [7:0] e3, input logic [7:0] e2,
                             input logic [7:0] e1, input logic [7:0] e0);
      exp_q.push_back(e0);
      exp_q.push_back(e1);
      exp_q.push_back(e2);
      exp_q.push_back(e3);
   endtask

   // Align to the first cycle of a fresh d0 slot, then compare a whole frame
   task automatic capture_frame(input string name);
      logic [7:0] e;
      wait_com(4'b1101, name);
      wait_com(4'b1110, name);
      for (int d = 0; d < 4; d++) begin
         check($sformatf("%s_com%0d", name, d), {4'h0, oFnd_Com}, {4'h0, com_pat[d]});
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
         check($sformatf("%s_d%0d", name, d), oFnd_Data, e);
         if (d < 3) repeat (P_SCAN) @(negedge iClk);
      end
   endtask

   task automatic tick(input int count);
      for (int k = 0; k < count; k++) begin
         imSec_Tick = 1'b1;
         @(negedge iClk);
         imSec_Tick = 1'b0;
         @(negedge iClk);
      end
   endtask

   initial begin
      com_pat[0] = 4'b1110;
      com_pat[1] = 4'b1101;
      com_pat[2] = 4'b1011;
      com_pat[3] = 4'b0111;

      //            view  set    msec    sec    min    hour   d3     d2     d1     d0
      vecs[0] = '{1'b0, 2'b00, 7'd0,   6'd0,  6'd45, 5'd23, 8'hA4, 8'h30, 8'h99, 8'h92};
      vecs[1] = '{1'b1, 2'b00, 7'd99,  6'd7,  6'd45, 5'd23, 8'hC0, 8'h78, 8'h90, 8'h90};
      vecs[2] = '{1'b1, 2'b10, 7'd5,   6'd30, 6'd45, 5'd23, 8'hB0, 8'h40, 8'hC0, 8'h92};
      vecs[3] = '{1'b1, 2'b00, 7'd120, 6'd59, 6'd0,  5'd0,  8'h92, 8'h10, 8'hBF, 8'hBF};
      vecs[4] = '{1'b0, 2'b00, 7'd0,   6'd0,  6'd0,  5'd0,  8'hC0, 8'h40, 8'hC0, 8'hC0};
      vecs[5] = '{1'b0, 2'b00, 7'd0,   6'd0,  6'd59, 5'd9,  8'hC0, 8'h10, 8'h92, 8'h90};
      vecs[6] = '{1'b1, 2'b00, 7'd100, 6'd0,  6'd0,  5'd0,  8'hC0, 8'h40, 8'hBF, 8'hBF};
      vecs[7] = '{1'b0, 2'b11, 7'd0,   6'd0,  6'd34, 5'd12, 8'hF9, 8'h24, 8'hB0, 8'h99};

      iRst       = 1'b1;
      iView      = 1'b0;
      iSet       = 2'b00;
      imSec      = '0;
      iSec       = '0;
      iMin       = '0;
      iHour      = '0;
      imSec_Tick = 1'b0;

      // Reset state and first frame from the zero snapshot
      @(negedge iClk);
      check("rst_com", {4'h0, oFnd_Com}, 8'h0F);
      check("rst_data", oFnd_Data, 8'hFF);
      iRst = 1'b0;
      @(negedge iClk);
      check("first_com", {4'h0, oFnd_Com}, 8'h0E);
      check("first_data", oFnd_Data, 8'hC0);
      repeat (P_SCAN) @(negedge iClk);
      check("scan_d1_com", {4'h0, oFnd_Com}, 8'h0D);
      check("scan_d1_data", oFnd_Data, 8'hC0);
      repeat (P_SCAN) @(negedge iClk);
      check("scan_d2_com", {4'h0, oFnd_Com}, 8'h0B);
      check("scan_d2_data", oFnd_Data, 8'h40);
      repeat (P_SCAN) @(negedge iClk);
      check("scan_d3_com", {4'h0, oFnd_Com}, 8'h07);
      check("scan_d3_data", oFnd_Data, 8'hC0);
      repeat (P_SCAN) @(negedge iClk);
      check("scan_wrap_com", {4'h0, oFnd_Com}, 8'h0E);

      // Table of static display patterns
      for (int i = 0; i < 8; i++) begin
         iView = vecs[i].view;
         iSet  = vecs[i].set;
         imSec = vecs[i].msec;
         iSec  = vecs[i].sec;
         iMin  = vecs[i].min;
         iHour = vecs[i].hour;
         push_frame(vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].d0);
         capture_frame($sformatf("vec%0d", i));
      end

      // Hour set blinking
      iView = 1'b0; iHour = 5'd23; iMin = 6'd45; iSet = 2'b10;
      push_frame(8'hA4, 8'h30, 8'h99, 8'h92);
      capture_frame("hset_entry");
      tick(2);
      push_frame(8'hFF, 8'hFF, 8'h99, 8'h92);
      capture_frame("hset_blank");
      tick(2);
      push_frame(8'hA4, 8'h30, 8'h99, 8'h92);
      capture_frame("hset_restore");

      // Phase 0 with no set field: dp off only; then minute-set entry forces visible
      tick(2);
      iSet = 2'b00;
      push_frame(8'hA4, 8'hB0, 8'h99, 8'h92);
      capture_frame("none_phase0");
      iSet = 2'b01;
      push_frame(8'hA4, 8'h30, 8'h99, 8'h92);
      capture_frame("min_entry");

      // Set entry coincident with a tick: entry wins and restarts the count
      tick(2);
      iSet = 2'b00;
      push_frame(8'hA4, 8'hB0, 8'h99, 8'h92);
      capture_frame("pre_coinc");
      iSet       = 2'b10;
      imSec_Tick = 1'b1;
      @(negedge iClk);
      imSec_Tick = 1'b0;
      push_frame(8'hA4, 8'h30, 8'h99, 8'h92);
      capture_frame("entry_vs_tick");
      tick(1);
      push_frame(8'hA4, 8'h30, 8'h99, 8'h92);
      capture_frame("post_entry_tick");
      tick(1);
      push_frame(8'hFF, 8'hFF, 8'h99, 8'h92);
      capture_frame("post_entry_blank");

      // Snapshot holds until the frame boundary
      tick(2);
      iSet = 2'b00;
      push_frame(8'hA4, 8'h30, 8'h99, 8'h92);
      capture_frame("snap_base");
      wait_com(4'b1101, "snap_d1");
      iMin = 6'd46;
      @(negedge iClk);
      check("snap_d1_hold_com", {4'h0, oFnd_Com}, 8'h0D);
      check("snap_d1_hold", oFnd_Data, 8'h99);
      wait_com(4'b1110, "snap_d0");
      check("snap_new_d0", oFnd_Data, 8'h82);
      @(negedge iClk);
      iMin = 6'd47;
      @(negedge iClk);
      check("snap_d0_hold_com", {4'h0, oFnd_Com}, 8'h0E);
      check("snap_d0_hold", oFnd_Data, 8'h82);
      push_frame(8'hA4, 8'h30, 8'h99, 8'hF8);
      capture_frame("snap_next");

      // Reset in mid-operation with nonzero inputs and blink phase 0
      tick(2);
      iSet = 2'b10;
      @(negedge iClk);
      iRst = 1'b1;
      @(negedge iClk);
      check("rst2_com", {4'h0, oFnd_Com}, 8'h0F);
      check("rst2_data", oFnd_Data, 8'hFF);
      iRst = 1'b0;
      @(negedge iClk);
      check("rst2_first_com", {4'h0, oFnd_Com}, 8'h0E);
      check("rst2_first_data", oFnd_Data, 8'hC0);
      repeat (2 * P_SCAN) @(negedge iClk);
      check("rst2_d2_com", {4'h0, oFnd_Com}, 8'h0B);
      check("rst2_d2_data", oFnd_Data, 8'h40);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
